// File: rtl/ckpt_queue_state.sv
// Head/tail/valid state for a circular in-order structure with an internal bank of
// branch checkpoints that restore the tail on a mispredict.
`timescale 1ns/1ps
module ckpt_queue_state #(
    parameter int DEPTH    = 32,
    parameter int ALLOC_W  = 2,
    parameter int RETIRE_W = 2,
    parameter int NUM_CKPT = 4,
    parameter int IDW      = $clog2(DEPTH),
    parameter int CW       = $clog2(NUM_CKPT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(ALLOC_W+1)-1:0]    alloc_count,
    output logic                            alloc_ready,
    output logic [ALLOC_W*IDW-1:0]          alloc_ids,
    input  logic [$clog2(RETIRE_W+1)-1:0]   retire_count,
    output logic [IDW-1:0]                  head_id,
    output logic [IDW:0]                    count,
    output logic                            empty,
    output logic                            full,
    output logic [DEPTH-1:0]                entry_valid,
    input  logic                            ckpt_take,
    output logic                            ckpt_avail,
    output logic [CW-1:0]                   ckpt_id,
    input  logic                            ckpt_free,
    input  logic [CW-1:0]                   ckpt_free_id,
    input  logic                            branch_miss,
    input  logic [CW-1:0]                   miss_ckpt_id
);
    localparam int PW = IDW + 1;

    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [NUM_CKPT-1:0] cv_q, cv_d;
    logic [CW-1:0]       wp_q, wp_d;
    logic [PW-1:0]       snap_q [NUM_CKPT];

    logic [PW-1:0]  free_space, alloc_ext, retire_ext, ret_n, acc_alloc, miss_span, miss_snap;
    logic           alloc_ok, miss_ok, take_ok, hold;
    logic [IDW-1:0] off_h, off_t, off_s;
    logic [CW-1:0]  cdist, coff;

    assign count       = tail_q - head_q;
    assign empty       = (count == '0);
    assign full        = (count == PW'(DEPTH));
    assign free_space  = PW'(DEPTH) - count;
    assign alloc_ready = (free_space >= PW'(ALLOC_W));
    assign head_id     = head_q[IDW-1:0];
    assign entry_valid = valid_q;
    assign ckpt_avail  = !cv_q[wp_q];
    assign ckpt_id     = wp_q;

    always_comb begin
        alloc_ids = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_ids[i*IDW +: IDW] = tail_q[IDW-1:0] + IDW'(i);
        end
    end

    assign alloc_ext  = PW'(alloc_count);
    assign retire_ext = PW'(retire_count);
    assign alloc_ok   = (alloc_ext <= free_space);
    assign acc_alloc  = alloc_ok ? alloc_ext : '0;
    assign ret_n      = (retire_ext > count) ? count : retire_ext;
    assign miss_ok    = branch_miss && cv_q[miss_ckpt_id];
    assign take_ok    = ckpt_take && ckpt_avail && !branch_miss;
    // A miss naming a dead checkpoint freezes the whole cycle rather than guessing.
    assign hold       = branch_miss && !miss_ok;
    assign miss_snap  = snap_q[miss_ckpt_id];
    assign miss_span  = tail_q - miss_snap;
    assign cdist      = wp_q - miss_ckpt_id;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        cv_d    = cv_q;
        wp_d    = wp_q;
        off_h   = '0;
        off_t   = '0;
        off_s   = '0;
        coff    = '0;
        if (!hold) begin
            head_d = head_q + ret_n;
            tail_d = miss_ok ? miss_snap : (tail_q + acc_alloc);
            for (int i = 0; i < DEPTH; i++) begin
                off_h = IDW'(i) - head_q[IDW-1:0];
                off_t = IDW'(i) - tail_q[IDW-1:0];
                off_s = IDW'(i) - miss_snap[IDW-1:0];
                if (PW'(off_h) < ret_n)
                    valid_d[i] = 1'b0;
                if (!miss_ok && (PW'(off_t) < acc_alloc))
                    valid_d[i] = 1'b1;
                if (miss_ok && (PW'(off_s) < miss_span))
                    valid_d[i] = 1'b0;
            end
            if (ckpt_free)
                cv_d[ckpt_free_id] = 1'b0;
            if (take_ok) begin
                cv_d[wp_q] = 1'b1;
                wp_d       = wp_q + 1'b1;
            end
            // cdist==0 with a valid miss id means the ring wrapped: every other id is younger.
            if (miss_ok) begin
                for (int j = 0; j < NUM_CKPT; j++) begin
                    coff = CW'(j) - miss_ckpt_id;
                    if ((cdist == '0) || (coff < cdist))
                        cv_d[j] = 1'b0;
                end
                wp_d = miss_ckpt_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            cv_q    <= '0;
            wp_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            cv_q    <= cv_d;
            wp_q    <= wp_d;
        end
    end

    // Snapshot includes this cycle's accepted allocation so the branch's own slots survive.
    always_ff @(posedge clk) begin
        if (rst_n && take_ok)
            snap_q[wp_q] <= tail_q + acc_alloc;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!branch_miss)
                assert (alloc_ok) else
                    $warning("ckpt_queue_state: allocate %0d exceeds free %0d, dropped", alloc_count, free_space);
            assert (retire_ext <= count) else
                $warning("ckpt_queue_state: retire %0d exceeds count %0d, clamped", retire_count, count);
            if (ckpt_take && !branch_miss)
                assert (ckpt_avail) else
                    $warning("ckpt_queue_state: checkpoint take with no free slot ignored");
            if (branch_miss)
                assert (cv_q[miss_ckpt_id]) else
                    $warning("ckpt_queue_state: branch miss on invalid checkpoint %0d ignored", miss_ckpt_id);
        end
    end
endmodule

// File: tb/tb_ckpt_queue_state.sv
// Directed bench for ckpt_queue_state: fill/full, drop-on-full, checkpoint restore,
// checkpoint ring reuse, pointer wrap, miss with retire, and reset override.
`timescale 1ns/1ps
module tb_ckpt_queue_state;
    localparam int DEPTH = 32, ALLOC_W = 4, RETIRE_W = 4, NUM_CKPT = 4;
    localparam int IDW = 5, CW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [2:0]             alloc_count = '0;
    logic                   alloc_ready;
    logic [ALLOC_W*IDW-1:0] alloc_ids;
    logic [2:0]             retire_count = '0;
    logic [IDW-1:0]         head_id;
    logic [IDW:0]           count;
    logic                   empty, full;
    logic [DEPTH-1:0]       entry_valid;
    logic                   ckpt_take = 1'b0;
    logic                   ckpt_avail;
    logic [CW-1:0]          ckpt_id;
    logic                   ckpt_free = 1'b0;
    logic [CW-1:0]          ckpt_free_id = '0;
    logic                   branch_miss = 1'b0;
    logic [CW-1:0]          miss_ckpt_id = '0;

    int vectors = 0;
    int miscompares = 0;

    ckpt_queue_state #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .RETIRE_W(RETIRE_W), .NUM_CKPT(NUM_CKPT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_count(alloc_count), .alloc_ready(alloc_ready), .alloc_ids(alloc_ids),
        .retire_count(retire_count), .head_id(head_id), .count(count),
        .empty(empty), .full(full), .entry_valid(entry_valid),
        .ckpt_take(ckpt_take), .ckpt_avail(ckpt_avail), .ckpt_id(ckpt_id),
        .ckpt_free(ckpt_free), .ckpt_free_id(ckpt_free_id),
        .branch_miss(branch_miss), .miss_ckpt_id(miss_ckpt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int ac, input int rc, input bit tk, input bit fr, input int fid,
                        input bit ms, input int mid);
        alloc_count  = 3'(ac);
        retire_count = 3'(rc);
        ckpt_take    = tk;
        ckpt_free    = fr;
        ckpt_free_id = CW'(fid);
        branch_miss  = ms;
        miss_ckpt_id = CW'(mid);
        @(posedge clk);
        #1;
        alloc_count  = '0;
        retire_count = '0;
        ckpt_take    = 1'b0;
        ckpt_free    = 1'b0;
        branch_miss  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_alloc_ready"}, 64'(alloc_ready), 64'd1);
        chk({tag, "_ckpt_avail"}, 64'(ckpt_avail), 64'd1);
        chk({tag, "_ckpt_id"}, 64'(ckpt_id), 64'd0);
        chk({tag, "_head_id"}, 64'(head_id), 64'd0);
        chk({tag, "_entry_valid"}, 64'(entry_valid), 64'd0);
        chk({tag, "_alloc_ids"}, 64'(alloc_ids), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        chk_reset("rst0");
        rst_n = 1'b1;

        // Fill to full, two per cycle
        step(2, 0, 0, 0, 0, 0, 0);
        chk("fill1_count", 64'(count), 64'd2);
        chk("fill1_valid", 64'(entry_valid), 64'h3);
        for (int k = 0; k < 15; k++) step(2, 0, 0, 0, 0, 0, 0);
        chk("full_count", 64'(count), 64'd32);
        chk("full_full", 64'(full), 64'd1);
        chk("full_empty", 64'(empty), 64'd0);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_valid", 64'(entry_valid), 64'hFFFF_FFFF);
        chk("full_ids", 64'(alloc_ids), 64'({5'd3, 5'd2, 5'd1, 5'd0}));

        // Allocate against pre-retire full is dropped; retire still happens
        step(1, 2, 0, 0, 0, 0, 0);
        chk("drop_count", 64'(count), 64'd30);
        chk("drop_head", 64'(head_id), 64'd2);
        chk("drop_valid", 64'(entry_valid), 64'hFFFF_FFFC);
        chk("drop_full", 64'(full), 64'd0);
        chk("drop_ready", 64'(alloc_ready), 64'd0);
        chk("drop_ids", 64'(alloc_ids), 64'({5'd3, 5'd2, 5'd1, 5'd0}));

        // Checkpoint restore after younger allocation
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(5, 0, 0, 0, 0, 0, 0);
        chk("a5_count", 64'(count), 64'd5);
        step(2, 0, 1, 0, 0, 0, 0);
        chk("take0_count", 64'(count), 64'd7);
        chk("take0_id", 64'(ckpt_id), 64'd1);
        step(6, 0, 0, 0, 0, 0, 0);
        chk("a6_count", 64'(count), 64'd13);
        chk("a6_valid", 64'(entry_valid), 64'h1FFF);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("miss0_count", 64'(count), 64'd7);
        chk("miss0_valid", 64'(entry_valid), 64'h7F);
        chk("miss0_ckpt_id", 64'(ckpt_id), 64'd0);
        chk("miss0_avail", 64'(ckpt_avail), 64'd1);
        chk("miss0_ids", 64'(alloc_ids), 64'({5'd10, 5'd9, 5'd8, 5'd7}));

        // Fill the checkpoint ring, free one out of order, miss in the middle
        for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 0, 0, 0);
        chk("ring_count", 64'(count), 64'd11);
        chk("ring_id", 64'(ckpt_id), 64'd0);
        chk("ring_avail", 64'(ckpt_avail), 64'd0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("free1_avail", 64'(ckpt_avail), 64'd0);
        chk("free1_id", 64'(ckpt_id), 64'd0);
        step(0, 0, 0, 0, 0, 1, 2);
        chk("miss2_count", 64'(count), 64'd10);
        chk("miss2_valid", 64'(entry_valid), 64'h3FF);
        chk("miss2_id", 64'(ckpt_id), 64'd2);
        chk("miss2_avail", 64'(ckpt_avail), 64'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("reuse2_id", 64'(ckpt_id), 64'd3);
        chk("id3_cleared", 64'(ckpt_avail), 64'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("reuse3_id", 64'(ckpt_id), 64'd0);
        chk("id0_kept", 64'(ckpt_avail), 64'd0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("free0_avail", 64'(ckpt_avail), 64'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("reuse0_id", 64'(ckpt_id), 64'd1);
        chk("id1_freed", 64'(ckpt_avail), 64'd1);

        // Move head/tail to 30, then wrap across DEPTH
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) step(4, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0);
        chk("pre_count", 64'(count), 64'd30);
        for (int k = 0; k < 7; k++) step(0, 4, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 0);
        chk("at30_empty", 64'(empty), 64'd1);
        chk("at30_head", 64'(head_id), 64'd30);
        chk("at30_valid", 64'(entry_valid), 64'h0);
        chk("at30_ids", 64'(alloc_ids), 64'({5'd1, 5'd0, 5'd31, 5'd30}));
        step(4, 0, 1, 0, 0, 0, 0);
        chk("wtake_count", 64'(count), 64'd4);
        chk("wtake_id", 64'(ckpt_id), 64'd1);
        chk("wtake_valid", 64'(entry_valid), 64'hC000_0003);
        step(3, 0, 0, 0, 0, 0, 0);
        chk("wa3_count", 64'(count), 64'd7);
        chk("wa3_valid", 64'(entry_valid), 64'hC000_001F);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("wmiss_count", 64'(count), 64'd4);
        chk("wmiss_valid", 64'(entry_valid), 64'hC000_0003);
        chk("wmiss_ids", 64'(alloc_ids), 64'({5'd5, 5'd4, 5'd3, 5'd2}));
        chk("wmiss_head", 64'(head_id), 64'd30);
        chk("wmiss_ckpt_id", 64'(ckpt_id), 64'd0);

        // Miss with same-cycle retire and (discarded) allocate
        step(2, 0, 1, 0, 0, 0, 0);
        chk("mr_take_count", 64'(count), 64'd6);
        step(3, 0, 0, 0, 0, 0, 0);
        chk("mr_pre_valid", 64'(entry_valid), 64'hC000_007F);
        step(2, 2, 0, 0, 0, 1, 0);
        chk("mr_count", 64'(count), 64'd4);
        chk("mr_head", 64'(head_id), 64'd0);
        chk("mr_valid", 64'(entry_valid), 64'h0000_000F);
        chk("mr_ids", 64'(alloc_ids), 64'({5'd7, 5'd6, 5'd5, 5'd4}));
        chk("mr_ckpt_id", 64'(ckpt_id), 64'd0);

        // Reset overrides a busy cycle including a valid miss
        step(1, 0, 1, 0, 0, 0, 0);
        chk("pre_rst_id", 64'(ckpt_id), 64'd1);
        rst_n = 1'b0;
        step(2, 1, 1, 1, 0, 1, 0);
        chk_reset("rst_mid");
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_valid", 64'(entry_valid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
